esp_uart_rx: RTL and testbench

ESP_UART_RX -- requirements
Module: esp_uart_rx

---
 rtl/esp_uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_esp_uart_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/esp_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : esp_uart_rx
//  Description : 8N1 UART receiver for the ESP serial link with 16x
//                oversampling, a receive FIFO and an Avalon-MM slave.
//                Ports:
//                  clk_clk        - sole clock
//                  reset_reset_n  - asynchronous active-low reset
//                  esp_uart_rxd   - serial input, idle high, LSB first
//                  avs_address    - word address (0 DATA, 1 STATUS,
//                                   2 CONTROL, 3 reserved)
//                  avs_read/avs_write/avs_writedata/avs_readdata
//                                 - Avalon-MM slave, read latency 1
//                  irq            - level interrupt (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module esp_uart_rx #(
    parameter int CLK_DIV    = 27,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        esp_uart_rxd,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d, framing_err_q, framing_err_d;
    logic             irq_en_q, irq_en_d, irq_q, irq_d;
    logic [31:0]      readdata_q, readdata_d;

    logic       fall, tick, start_entry, start_sample, bit_sample;
    logic       push_req, do_push, pop, full, empty, status_wr;
    logic [6:0] count_ext;
    logic       unused_wdata;

    // Falling edge is seen on the synchronized line only, so a held-low
    // break cannot re-arm reception until the line has gone high again.
    assign fall         = rx_prev_q & ~sync2_q;
    assign tick         = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign start_entry  = (state_q == S_IDLE) && fall;
    assign start_sample = tick && (state_q == S_START) && (tick_cnt_q == 4'd7);
    assign bit_sample   = tick && ((state_q == S_DATA) || (state_q == S_STOP))
                          && (tick_cnt_q == 4'd15);
    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign count_ext    = 7'(count_q);
    assign unused_wdata = ^{avs_writedata[31:10], avs_writedata[7:1]};

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fall) state_d = S_START;
            S_START: if (start_sample) state_d = sync2_q ? S_IDLE : S_DATA;
            S_DATA:  if (bit_sample && bit_idx_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (bit_sample) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        sync1_d       = esp_uart_rxd;
        sync2_d       = sync1_q;
        rx_prev_d     = sync2_q;
        div_cnt_d     = (start_entry || tick) ? '0 : div_cnt_q + DIV_W'(1);
        tick_cnt_d    = tick_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        irq_en_d      = irq_en_q;
        readdata_d    = readdata_q;

        if (start_entry || start_sample) tick_cnt_d = 4'd0;
        else if (tick)                   tick_cnt_d = tick_cnt_q + 4'd1;

        if (start_sample) bit_idx_d = 3'd0;
        if (bit_sample && state_q == S_DATA) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {sync2_q, shift_q[7:1]};
        end

        push_req = bit_sample && (state_q == S_STOP) && sync2_q;
        pop      = avs_read && (avs_address == 2'd0) && !empty;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        do_push  = push_req && (!full || pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set wins over a same-cycle clear.
        status_wr     = avs_write && (avs_address == 2'd1);
        overrun_d     = (push_req && full && !pop) ||
                        (overrun_q && !(status_wr && avs_writedata[9]));
        framing_err_d = (bit_sample && (state_q == S_STOP) && !sync2_q) ||
                        (framing_err_q && !(status_wr && avs_writedata[8]));

        if (avs_write && avs_address == 2'd2) irq_en_d = avs_writedata[0];
        irq_d = irq_en_q & (!empty | overrun_q | framing_err_q);

        if (avs_read) begin
            case (avs_address)
                2'd0:    readdata_d = empty ? 32'd0
                                            : {23'd0, 1'b1, mem_q[rd_ptr_q]};
                2'd1:    readdata_d = {20'd0, full, empty, overrun_q,
                                       framing_err_q, 1'b0, count_ext};
                2'd2:    readdata_d = {31'd0, irq_en_q};
                default: readdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            div_cnt_q     <= '0;
            tick_cnt_q    <= 4'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
            framing_err_q <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_q         <= 1'b0;
            readdata_q    <= 32'd0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rx_prev_q     <= rx_prev_d;
            div_cnt_q     <= div_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overrun_q     <= overrun_d;
            framing_err_q <= framing_err_d;
            irq_en_q      <= irq_en_d;
            irq_q         <= irq_d;
            readdata_q    <= readdata_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_clk) begin
        mem_q <= mem_d;
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_esp_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_esp_uart_rx
//  Description : Self-checking bench for esp_uart_rx. Reads push expected
//                data into a queue; a monitor compares on readdata return.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_esp_uart_rx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int BIT_CYC    = 16 * CLK_DIV;

    logic        clk_clk       = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        esp_uart_rxd  = 1'b1;
    logic [1:0]  avs_address   = 2'd0;
    logic        avs_read      = 1'b0;
    logic        avs_write     = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_seen = 1'b0;

    esp_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .esp_uart_rxd  (esp_uart_rxd),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) rd_seen <= avs_read;

    // Monitor: one expected entry per returned read.
    always @(negedge clk_clk) begin
        if (rd_seen) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read got=%h want=none", avs_readdata);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (avs_readdata !== e) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h", n, avs_readdata, e);
                end
            end
        end
    end

    task automatic line(input logic v, input int n);
        esp_uart_rxd = v;
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) line(b[i], BIT_CYC);
        line(stop, BIT_CYC);
        if (!stop) begin
            line(1'b0, 2 * BIT_CYC);   // extended break
            line(1'b1, BIT_CYC);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk_clk); #1;
        avs_read = 1'b0;
        @(posedge clk_clk); #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk_clk); #1;
        avs_write = 1'b0;
        @(posedge clk_clk); #1;
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] e);
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, got, e);
        end
    endtask

    initial begin
        logic [7:0] b;

        // Reset
        repeat (3) @(posedge clk_clk);
        #1;
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset_reset_n = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1;
        rd(2'd1, 32'h400, "rst_status");

        // Two frames back to back
        send_byte(8'h55, 1'b1);
        send_byte(8'hA3, 1'b1);
        line(1'b1, 20);
        rd(2'd1, 32'h002, "two_status");
        rd(2'd0, 32'h155, "two_data0");
        rd(2'd0, 32'h1A3, "two_data1");
        rd(2'd0, 32'h000, "two_empty_rd");
        rd(2'd1, 32'h400, "two_status_after");

        // Glitch shorter than half a bit
        line(1'b0, 20);
        line(1'b1, 2 * BIT_CYC);
        rd(2'd1, 32'h400, "glitch_status");

        // Framing error then clear
        send_byte(8'h7E, 1'b0);
        line(1'b1, 20);
        rd(2'd1, 32'h500, "ferr_status");
        wr(2'd1, 32'h100);
        rd(2'd1, 32'h400, "ferr_cleared");

        // Control and reserved address
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'h1, "ctrl_rd");
        chk("irq_en_idle", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h0);
        rd(2'd2, 32'h0, "ctrl_clr");
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, 32'h0, "addr3_rd");

        // Overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 13 + 5);
            send_byte(b, 1'b1);
        end
        line(1'b1, 20);
        rd(2'd1, 32'hA10, "ovr_status");
        rd(2'd0, 32'h105, "ovr_first");
        rd(2'd1, 32'h20F, "ovr_status_pop");
        for (int i = 1; i < 16; i++) begin
            b = 8'(i * 13 + 5);
            rd(2'd0, {23'd0, 1'b1, b}, "ovr_drain");
        end
        rd(2'd0, 32'h000, "ovr_drained");
        rd(2'd1, 32'h600, "ovr_empty_status");
        wr(2'd1, 32'h200);
        rd(2'd1, 32'h400, "ovr_cleared");

        // Interrupt
        wr(2'd2, 32'h1);
        chk("irq_quiet", {31'd0, irq}, 32'd0);
        send_byte(8'h5A, 1'b1);
        line(1'b1, 20);
        chk("irq_set", {31'd0, irq}, 32'd1);
        avs_address = 2'd0;
        avs_read    = 1'b1;
        exp_q.push_back(32'h15A);
        name_q.push_back("irq_data");
        @(posedge clk_clk); #1;
        avs_read = 1'b0;
        chk("irq_at_readdata", {31'd0, irq}, 32'd1);
        @(posedge clk_clk); #1;
        chk("irq_after_pop", {31'd0, irq}, 32'd0);

        // Reset during data bit 4 of 0x3C
        b = 8'h3C;
        line(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) line(b[i], BIT_CYC);
        line(b[4], BIT_CYC / 2);
        reset_reset_n = 1'b0;
        esp_uart_rxd  = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        reset_reset_n = 1'b1;
        line(1'b1, 3 * BIT_CYC);
        rd(2'd1, 32'h400, "midrst_status");
        rd(2'd2, 32'h0, "midrst_ctrl");
        send_byte(8'h3C, 1'b1);
        line(1'b1, 20);
        rd(2'd1, 32'h001, "midrst_status_frame");
        rd(2'd0, 32'h13C, "midrst_data");

        // Every issued read must have been answered
        repeat (4) @(posedge clk_clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_reads got=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
